// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder with bit-unstuffing and word assembly.
// Line transitions decode to 0 and held levels decode to 1. After STUFF_LEN
// consecutive decoded 1s, the next sample is a stuff bit and is dropped.
module nrzi_rx_decoder #(
  parameter int       WIDTH      = 8,
  parameter int       STUFF_LEN  = 6,
  parameter bit       IDLE_LEVEL = 1'b1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     shift_en,
  input  logic                     d_in,
  input  logic                     clear,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic                     stuff_err,
  output logic [$clog2(WIDTH):0]   bit_cnt
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {RUN, STUFF} state_t;

  state_t             state_q;
  logic               prevLevel_q;
  logic [3:0]         ones_q;
  logic [CW-1:0]      bitCnt_q;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   dataOut_q;
  logic               dataValid_q;
  logic               bitOut_q;
  logic               bitValid_q;
  logic               stuffErr_q;

  logic               decBit_d;
  logic [WIDTH-1:0]   shift_d;
  logic               wordDone_d;
  logic               stuffHit_d;

  // Decode the current sample and precompute the shifted word and stuff trigger.
  always_comb begin
    decBit_d   = (d_in == prevLevel_q);
    shift_d    = {decBit_d, shift_q[WIDTH-1:1]};
    wordDone_d = (bitCnt_q == CW'(WIDTH - 1));
    stuffHit_d = decBit_d && ((ones_q + 4'd1) == 4'(STUFF_LEN));
  end

  // Decoder FSM: pulses default low; clear beats a sample; idle cycles hold state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= RUN;
      prevLevel_q <= IDLE_LEVEL;
      ones_q      <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      bitOut_q    <= 1'b0;
      bitValid_q  <= 1'b0;
      stuffErr_q  <= 1'b0;
    end else begin
      dataValid_q <= 1'b0;
      bitValid_q  <= 1'b0;
      stuffErr_q  <= 1'b0;
      if (clear) begin
        state_q     <= RUN;
        prevLevel_q <= IDLE_LEVEL;
        ones_q      <= '0;
        bitCnt_q    <= '0;
        shift_q     <= '0;
      end else if (shift_en) begin
        prevLevel_q <= d_in;
        case (state_q)
          RUN: begin
            bitOut_q   <= decBit_d;
            bitValid_q <= 1'b1;
            if (wordDone_d) begin
              dataOut_q   <= shift_d;
              dataValid_q <= 1'b1;
              bitCnt_q    <= '0;
              shift_q     <= '0;
            end else begin
              shift_q  <= shift_d;
              bitCnt_q <= bitCnt_q + CW'(1);
            end
            if (!decBit_d) begin
              ones_q <= '0;
            end else if (stuffHit_d) begin
              ones_q  <= '0;
              state_q <= STUFF;
            end else begin
              ones_q <= ones_q + 4'd1;
            end
          end
          STUFF: begin
            state_q    <= RUN;
            ones_q     <= '0;
            stuffErr_q <= decBit_d;
          end
          default: begin
            state_q <= RUN;
          end
        endcase
      end
    end
  end

  assign data_out   = dataOut_q;
  assign data_valid = dataValid_q;
  assign bit_out    = bitOut_q;
  assign bit_valid  = bitValid_q;
  assign stuff_err  = stuffErr_q;
  assign bit_cnt    = bitCnt_q;

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed testbench for nrzi_rx_decoder with WIDTH=8, STUFF_LEN=6, IDLE_LEVEL=1.
module tb_nrzi_rx_decoder;

  logic       clk;
  logic       n_rst;
  logic       shift_en;
  logic       d_in;
  logic       clear;
  logic [7:0] data_out;
  logic       data_valid;
  logic       bit_out;
  logic       bit_valid;
  logic       stuff_err;
  logic [3:0] bit_cnt;

  int testCount;
  int failCount;

  logic [7:0] syncSeq;

  nrzi_rx_decoder #(.WIDTH(8), .STUFF_LEN(6), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .shift_en   (shift_en),
    .d_in       (d_in),
    .clear      (clear),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .stuff_err  (stuff_err),
    .bit_cnt    (bit_cnt)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one strobed sample at the falling edge, return just after the rising edge.
  task automatic applyStimulus(input logic b);
    @(negedge clk);
    shift_en = 1'b1;
    d_in     = b;
    clear    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One cycle with no strobe and no clear.
  task automatic idleCycle(input logic b);
    @(negedge clk);
    shift_en = 1'b0;
    clear    = 1'b0;
    d_in     = b;
    @(posedge clk);
    #1;
  endtask

  // One clear cycle, optionally with a simultaneous strobe.
  task automatic clearCycle(input logic withStrobe, input logic b);
    @(negedge clk);
    shift_en = withStrobe;
    clear    = 1'b1;
    d_in     = b;
    @(posedge clk);
    #1;
    @(negedge clk);
    clear    = 1'b0;
    shift_en = 1'b0;
  endtask

  // Feed the SYNC pattern and check per-bit counters and the final word.
  task automatic runSync(input string tag);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(syncSeq[7-i]);
      checkOutput({tag, "_bitcnt"}, 32'(bit_cnt), 32'((i + 1) % 8));
      checkOutput({tag, "_bitvalid"}, 32'(bit_valid), 32'd1);
      checkOutput({tag, "_bitout"}, 32'(bit_out), (i == 7) ? 32'd1 : 32'd0);
      checkOutput({tag, "_dvalid"}, 32'(data_valid), (i == 7) ? 32'd1 : 32'd0);
    end
    checkOutput({tag, "_word"}, 32'(data_out), 32'h80);
    idleCycle(1'b0);
    checkOutput({tag, "_dvalid_drop"}, 32'(data_valid), 32'd0);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    syncSeq   = 8'b0101_0100;   // d_in 0,1,0,1,0,1,0,0 in sending order (MSB first here)
    n_rst     = 1'b0;
    shift_en  = 1'b0;
    d_in      = 1'b1;
    clear     = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_data_out", 32'(data_out), 32'h0);
    checkOutput("rst_dvalid", 32'(data_valid), 32'd0);
    checkOutput("rst_bit_out", 32'(bit_out), 32'd0);
    checkOutput("rst_bvalid", 32'(bit_valid), 32'd0);
    checkOutput("rst_stuff_err", 32'(stuff_err), 32'd0);
    checkOutput("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // SYNC pattern
    runSync("sync");

    // Bit stuffing: 6 ones, stuff 0, then two more ones
    clearCycle(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i < 6) ? 1'b1 : 1'b0);
      checkOutput("stuff_bvalid", 32'(bit_valid), (i == 6) ? 32'd0 : 32'd1);
      checkOutput("stuff_err_low", 32'(stuff_err), 32'd0);
    end
    checkOutput("stuff_word", 32'(data_out), 32'hFF);
    checkOutput("stuff_dvalid", 32'(data_valid), 32'd1);
    checkOutput("stuff_bitcnt", 32'(bit_cnt), 32'd0);

    // Stuff error: line held high for 7 samples
    clearCycle(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1);
      checkOutput("serr_pulse", 32'(stuff_err), (i == 6) ? 32'd1 : 32'd0);
    end
    checkOutput("serr_bitcnt", 32'(bit_cnt), 32'd6);
    applyStimulus(1'b1);
    checkOutput("serr_next_bitcnt", 32'(bit_cnt), 32'd7);
    checkOutput("serr_drop", 32'(stuff_err), 32'd0);
    checkOutput("serr_next_bitout", 32'(bit_out), 32'd1);

    // Clear after 3 data bits; data_out from the stuffing test must hold
    clearCycle(1'b0, 1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("clr_pre_bitcnt", 32'(bit_cnt), 32'd3);
    clearCycle(1'b0, 1'b0);
    checkOutput("clr_bitcnt", 32'(bit_cnt), 32'd0);
    checkOutput("clr_data_hold", 32'(data_out), 32'hFF);
    checkOutput("clr_bvalid", 32'(bit_valid), 32'd0);
    runSync("clr_sync");

    // Asynchronous reset in the middle of a word
    for (int i = 0; i < 5; i++) applyStimulus(syncSeq[7-i]);
    checkOutput("arst_pre_bitcnt", 32'(bit_cnt), 32'd5);
    @(negedge clk);
    shift_en = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("arst_data_out", 32'(data_out), 32'h0);
    checkOutput("arst_bit_cnt", 32'(bit_cnt), 32'd0);
    checkOutput("arst_bit_out", 32'(bit_out), 32'd0);
    checkOutput("arst_bvalid", 32'(bit_valid), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    runSync("arst_sync");

    // shift_en low with a toggling line: nothing may move
    for (int i = 0; i < 20; i++) begin
      idleCycle(i[0]);
      checkOutput("hold_data_out", 32'(data_out), 32'h80);
      checkOutput("hold_bit_cnt", 32'(bit_cnt), 32'd0);
      checkOutput("hold_pulses", 32'({data_valid, bit_valid, stuff_err}), 32'd0);
    end

    // clear together with shift_en: the sample is dropped
    applyStimulus(1'b0);
    checkOutput("cs_pre_bitcnt", 32'(bit_cnt), 32'd1);
    clearCycle(1'b1, 1'b0);
    checkOutput("cs_bitcnt", 32'(bit_cnt), 32'd0);
    checkOutput("cs_bvalid", 32'(bit_valid), 32'd0);
    runSync("cs_sync");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
